// File: rtl/sbox_word_sequencer_pkg.sv
// Shared types for the byte-serial masked S-box word sequencer.
// The tag travels alongside each byte through the external S-box pipeline.
package sbox_word_sequencer_pkg;

  localparam int NUM_BYTES = 4;
  localparam logic [1:0] LAST_IDX = 2'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } tag_t;

  // Byte lane i of a 32-bit word, lane 0 = bits 7:0.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sbox_word_sequencer_tag_delay.sv
// LATENCY-deep shift register of lane tags mirroring the external S-box pipeline.
// A synchronous clear drops every in-flight tag so stale results are never written.
module sbox_tag_delay
  import sbox_word_sequencer_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LATENCY-1];

endmodule

// File: rtl/sbox_word_sequencer.sv
// Feeds a two-share 32-bit word byte-serially into a masked S-box pipeline and
// reassembles the four masked results into a two-share word (masked SubWord).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and the payload is stable while valid is high.
module sbox_word_sequencer
  import sbox_word_sequencer_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [7:0]  sbox_in0,
  output logic [7:0]  sbox_in1,
  input  logic [7:0]  sbox_out0,
  input  logic [7:0]  sbox_out1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic        busy,
  output state_t      dbg_state
);

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;

  logic        accept;
  logic        feed_next;
  tag_t        tag_push;
  tag_t        tag_pop;
  logic        lane3_done;

  logic [31:0] share0_q;
  logic [31:0] share1_q;
  logic [7:0]  sbox_in0_q;
  logic [7:0]  sbox_in1_q;
  logic [31:0] out0_q;
  logic [31:0] out1_q;

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign idx_d      = idx_q + 2'd1;
  // Byte 0 is loaded on the accept edge; later bytes on each FEED edge but the last.
  assign feed_next  = (state_q == S_FEED) && (idx_q != LAST_IDX);
  assign tag_push   = '{valid: (state_q == S_FEED), idx: idx_q};
  assign lane3_done = tag_pop.valid && (tag_pop.idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_q    <= S_FEED;
            idx_q      <= 2'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_FEED: begin
          if (idx_q == LAST_IDX) state_q <= S_WAIT;
          else                   idx_q   <= idx_d;
        end
        S_WAIT: begin
          if (lane3_done) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sbox_tag_delay #(
    .LATENCY (LATENCY)
  ) u_tag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_i (tag_push),
    .tag_o (tag_pop)
  );

  // Share 0 datapath; kept in its own block so no share-1 bit ever reaches it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      share0_q   <= '0;
      sbox_in0_q <= '0;
      out0_q     <= '0;
    end else begin
      if (accept) begin
        share0_q   <= in0;
        sbox_in0_q <= get_byte(in0, 2'd0);
      end else if (feed_next) begin
        sbox_in0_q <= get_byte(share0_q, idx_d);
      end
      if (tag_pop.valid) out0_q[{tag_pop.idx, 3'b000} +: 8] <= sbox_out0;
    end
  end

  // Share 1 datapath, structurally identical to share 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      share1_q   <= '0;
      sbox_in1_q <= '0;
      out1_q     <= '0;
    end else begin
      if (accept) begin
        share1_q   <= in1;
        sbox_in1_q <= get_byte(in1, 2'd0);
      end else if (feed_next) begin
        sbox_in1_q <= get_byte(share1_q, idx_d);
      end
      if (tag_pop.valid) out1_q[{tag_pop.idx, 3'b000} +: 8] <= sbox_out1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sbox_in0  = sbox_in0_q;
  assign sbox_in1  = sbox_in1_q;
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign dbg_state = state_q;

endmodule
